// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encoding,
// memory geometry and port identifiers.
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  localparam int unsigned MEM_NIBBLES    = 32'd128;
  // A word spans four nibbles, so the last legal base leaves room for three more.
  localparam int unsigned LAST_WORD_ADDR = MEM_NIBBLES - 32'd4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_rr_arb2.sv
// Two-input round-robin picker; the last-served pointer advances only when
// the caller takes the offered grant.
module rr_arb2
  import data_memory_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_grant
);

  logic r_last;
  logic w_grant;

  // Grant selection: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    w_grant = PORT0;
    case (i_req)
      2'b01:   w_grant = PORT0;
      2'b10:   w_grant = PORT1;
      2'b11:   w_grant = ~r_last;
      default: w_grant = PORT0;
    endcase
  end

  // Last-served pointer; resets to port 1 so port 0 wins the first tie
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= PORT1;
    end else if (i_take) begin
      r_last <= w_grant;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and access sequencer sharing one single-ported,
// nibble-addressed data memory between two req/ack masters.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_write0,
  input  logic              i_write1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_err0,
  output logic              o_err1,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_write,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_read_data
);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_take;
  logic              w_grant;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_legal;

  logic              r_cap_port;
  logic              r_cap_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_write_data;
  logic              r_mem_write;
  logic              r_mem_read;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   ({i_req1, i_req0}),
    .i_take  (w_take),
    .o_grant (w_grant)
  );

  // Route the winning port's request fields and range-check the full address
  always_comb begin
    w_sel_write = i_write0;
    w_sel_addr  = i_addr0;
    w_sel_wdata = i_wdata0;
    case (w_grant)
      PORT1: begin
        w_sel_write = i_write1;
        w_sel_addr  = i_addr1;
        w_sel_wdata = i_wdata1;
      end
      default: begin
        w_sel_write = i_write0;
        w_sel_addr  = i_addr0;
        w_sel_wdata = i_wdata0;
      end
    endcase
    w_sel_legal = (w_sel_addr <= ADDR_W'(LAST_WORD_ADDR));
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and grant acceptance
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          w_take = 1'b1;
          if (w_sel_legal) begin
            w_next_state = ST_ACCESS;
          end else begin
            w_next_state = ST_ERROR;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS:  w_next_state = ST_RESPOND;
      ST_ERROR:   w_next_state = ST_RESPOND;
      ST_RESPOND: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: memory strobes are set on grant and dropped at the end of ACCESS;
  // the winner's Ack/Err/RData update together so they are valid in one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cap_port       <= PORT0;
      r_cap_write      <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_write      <= 1'b0;
      r_mem_read       <= 1'b0;
      r_ack0           <= 1'b0;
      r_ack1           <= 1'b0;
      r_err0           <= 1'b0;
      r_err1           <= 1'b0;
      r_rdata0         <= '0;
      r_rdata1         <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_cap_port  <= w_grant;
            r_cap_write <= w_sel_write;
            if (w_sel_legal) begin
              r_mem_address    <= w_sel_addr;
              r_mem_write_data <= w_sel_wdata;
              r_mem_write      <= w_sel_write;
              r_mem_read       <= ~w_sel_write;
            end
          end
        end
        ST_ACCESS: begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          if (r_cap_port == PORT1) begin
            r_ack1 <= 1'b1;
            r_err1 <= 1'b0;
            if (!r_cap_write) r_rdata1 <= i_mem_read_data;
          end else begin
            r_ack0 <= 1'b1;
            r_err0 <= 1'b0;
            if (!r_cap_write) r_rdata0 <= i_mem_read_data;
          end
        end
        ST_ERROR: begin
          if (r_cap_port == PORT1) begin
            r_ack1   <= 1'b1;
            r_err1   <= 1'b1;
            r_rdata1 <= '0;
          end else begin
            r_ack0   <= 1'b1;
            r_err0   <= 1'b1;
            r_rdata0 <= '0;
          end
        end
        default: begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack0           = r_ack0;
  assign o_ack1           = r_ack1;
  assign o_err0           = r_err0;
  assign o_err1           = r_err1;
  assign o_rdata0         = r_rdata0;
  assign o_rdata1         = r_rdata1;
  assign o_mem_address    = r_mem_address;
  assign o_mem_write_data = r_mem_write_data;
  assign o_mem_write      = r_mem_write;
  assign o_mem_read       = r_mem_read;

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port round-robin arbiter and access sequencer placed in front of the single-ported 16-bit, nibble-addressed, big-endian data memory. It lets the CPU load/store path (port 0) and a secondary master such as a loader or debug port (port 1) share the memory through a req/ack handshake. It also drives the memory's address, write-data and strobes from registers, and flags out-of-range word accesses instead of issuing them.

## Interface
- MEM_NIBBLES, 128: memory depth in 4-bit cells; last legal word base address = MEM_NIBBLES-4 (124)
- ADDR_W, 16: address width
- DATA_W, 16: word width (4 nibbles)

- Clock  in  1  single clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Req0 / Req1  in  1  access request from port n; held until Ackn
- Write0 / Write1  in  1  1 = store, 0 = load; stable while Reqn high
- Addr0 / Addr1  in  ADDR_W  nibble address of word MSB nibble; stable while Reqn high
- WData0 / WData1  in  DATA_W  store data; stable while Reqn high
- Ack0 / Ack1  out  1  one-cycle completion pulse
- RData0 / RData1  out  DATA_W  load result; valid in the Ack cycle, held until next completion on that port
- Err0 / Err1  out  1  valid with Ack; 1 = address out of range, no memory access made
- MemAddress  out  ADDR_W  registered address to memory
- MemWriteData  out  DATA_W  registered write data to memory
- MemWrite  out  1  registered write strobe; memory commits on the rising edge ending the ACCESS cycle
- MemRead  out  1  registered read strobe; informational, high during load ACCESS
- MemReadData  in  DATA_W  combinational read data from memory

## Operation
- FSM states: IDLE, ACCESS, RESPOND, ERROR.
- IDLE: if any Reqn, pick a winner, capture its Write/Addr/WData and port id. Go to ACCESS if Addr ≤ MEM_NIBBLES-4, else ERROR. No request: stay.
- ACCESS: MemAddress = captured addr; MemWrite = captured write; MemRead = !captured write. At the ending edge, latch MemReadData into the winner's RData (loads only), go to RESPOND.
- ERROR: no strobes. Winner's RData is cleared to 0 and Err is set. Go to RESPOND.
- RESPOND: Ack of the winner is 1 for this cycle only, and Err is valid. Go to IDLE unconditionally.
- Arbitration is round-robin, using a 1-bit last-served pointer that is updated when a grant is taken in IDLE.
  - Only one requester: it wins.
  - Both requesting: the port not last served wins.
  - The pointer resets to 1, so port 0 wins the first tie.
- Requester rule: Reqn must drop in the cycle after Ackn. If it is still high in the following IDLE, that is a new request.
- Stores leave RDatan unchanged. Err is 0 on successful accesses.
- The losing port's request stays pending with no timeout. Its latency is at most one foreign transaction (3 cycles) plus its own.

## Timing
- Reset values: state IDLE, pointer 1. MemAddress, MemWriteData, MemWrite, MemRead, Ack0/1, Err0/1, RData0/1 all 0.
- Latency: Req sampled high at edge k. ACCESS runs during cycle k..k+1. Ack is high during cycle k+1..k+2. RData/Err are valid with Ack. The next grant is sampled at edge k+3.
- Peak throughput: one word access per 3 cycles.
- Store followed by load of the same address (either port order): the load returns the new data, because the write commits at the end of its ACCESS before the next ACCESS.
- Boundaries:
  - Addr = 124: legal, touches nibbles 124..127.
  - Addr = 125: ERROR.
  - Any address wraps or unsigned overflow: range check is done on the full ADDR_W value, with no wrap.
- Reset during ACCESS: MemWrite drops asynchronously and no write commits; no Ack is produced afterwards.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, ACCESS=1, RESPOND=2, ERROR=3)
  - MEM_NIBBLES and LAST_WORD_ADDR constants
  - port-id constants
- One sub-module, rr_arb2: a 2-input round-robin picker holding the pointer, with inputs req[1:0] and take, and output grant id. The FSM and datapath registers live in the top.

## Test plan
- Reset, then Req0 store 16'h1234 @2 → MemWrite high exactly one cycle with MemAddress=2. Ack0 is high 2 cycles after the sample edge with Err0=0. Memory nibbles 2..5 = 1,2,3,4.
- Port 1 load @2 after the previous store → RData1=16'h1234 with Ack1; MemWrite stays 0.
- Req0 and Req1 both asserted continuously for 4 transactions → grant order 0,1,0,1. Each Ack is a single-cycle pulse with a 3-cycle spacing.
- Req1 store @125 → no MemWrite/MemRead pulse; Ack1 with Err1=1 and RData1=0. Store @124 succeeds.
- Reset asserted mid-ACCESS of a store @10 → MemWrite low immediately and nibbles 10..13 unchanged. After release, all outputs are 0 and the first tie goes to port 0.
